// File: rtl/oric_kbd_pkg.sv
// Shared types and helpers for the Oric keyboard matrix scanner.
package oric_kbd_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int MAP_W       = MATRIX_ROWS * MATRIX_COLS;
  localparam int TIMER_W     = 16;

  // Explicit encodings keep the state values stable for older tooling and probes.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_PUBLISH = 3'd3,
    ST_GAP     = 3'd4
  } scan_state_t;

  function automatic logic [7:0] col_onecold(input logic [2:0] sel);
    return ~(8'b1 << sel);
  endfunction

endpackage

// File: rtl/kbd_scan_timer.sv
// Settle/gap counter: clears, counts when enabled, flags the last cycle before limit.
module kbd_scan_timer #(
  parameter int W = 16
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         last
);

  logic [W-1:0] count;
  logic [W:0]   count_inc;

  // last is high on the cycle whose increment would reach limit.
  assign count_inc = {1'b0, count} + {{W{1'b0}}, 1'b1};
  assign last      = (count_inc == {1'b0, limit});

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (en)
      count <= count_inc[W-1:0];
  end

endmodule

// File: rtl/kbd_scan_arbiter.sv
// Keyboard matrix arbiter: CPU has priority, idle cycles feed a background
// scanner that publishes a 64-bit key map snapshot.
module kbd_scan_arbiter
  import oric_kbd_pkg::*;
#(
  parameter int SETTLE    = 2,
  parameter int FRAME_GAP = 1000
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             scan_en,
  input  logic             cpu_req,
  input  logic [2:0]       cpu_row,
  input  logic [7:0]       cpu_col,
  input  logic             key_hit,
  output logic [2:0]       row,
  output logic [7:0]       col,
  output logic             cpu_key_hit,
  output logic [MAP_W-1:0] map,
  output logic             map_valid,
  output logic             frame_done,
  output logic             changed,
  output logic             any_key
);

  localparam logic [TIMER_W-1:0] SETTLE_CNT = TIMER_W'(SETTLE);
  localparam logic [TIMER_W-1:0] GAP_CNT    = TIMER_W'(FRAME_GAP);

  scan_state_t        state;
  logic [5:0]         idx;
  logic [MAP_W-1:0]   shadow;
  logic               cpu_req_d;
  logic               timer_clr;
  logic               timer_en;
  logic               timer_last;
  logic [TIMER_W-1:0] timer_limit;

  kbd_scan_timer #(.W(TIMER_W)) u_timer (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (timer_clr),
    .en      (timer_en),
    .limit   (timer_limit),
    .last    (timer_last)
  );

  always_comb begin
    if (cpu_req) begin
      row = cpu_row;
      col = cpu_col;
    end else if (state == ST_SETTLE || state == ST_SAMPLE) begin
      row = idx[5:3];
      col = col_onecold(idx[2:0]);
    end else begin
      row = 3'd0;
      col = 8'hFF;
    end
  end

  // Any CPU cycle during settle/sample restarts the current position from zero.
  always_comb begin
    timer_clr   = 1'b0;
    timer_en    = 1'b0;
    timer_limit = (state == ST_GAP) ? GAP_CNT : SETTLE_CNT;
    case (state)
      ST_SETTLE: begin
        timer_clr = cpu_req;
        timer_en  = ~cpu_req;
      end
      ST_GAP:  timer_en  = 1'b1;
      default: timer_clr = 1'b1;
    endcase
  end

  assign frame_done = (state == ST_PUBLISH);
  assign changed    = frame_done && ((shadow != map) || !map_valid);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= 6'd0;
      shadow    <= '0;
      map       <= '0;
      map_valid <= 1'b0;
      any_key   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (scan_en) begin
            idx    <= 6'd0;
            shadow <= '0;
            state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!scan_en)
            state <= ST_IDLE;
          else if (!cpu_req && timer_last)
            state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (!scan_en) begin
            state <= ST_IDLE;
          end else if (cpu_req) begin
            state <= ST_SETTLE;
          end else begin
            shadow[idx] <= key_hit;
            if (idx == 6'd63) begin
              state <= ST_PUBLISH;
            end else begin
              idx   <= idx + 6'd1;
              state <= ST_SETTLE;
            end
          end
        end
        ST_PUBLISH: begin
          map       <= shadow;
          any_key   <= |shadow;
          map_valid <= 1'b1;
          state     <= (FRAME_GAP == 0) ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          if (!scan_en || timer_last)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The first CPU cycle still carries the scanner's position, so it is skipped.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_req_d   <= 1'b0;
      cpu_key_hit <= 1'b0;
    end else begin
      cpu_req_d <= cpu_req;
      if (cpu_req && cpu_req_d)
        cpu_key_hit <= key_hit;
    end
  end

endmodule

// File: tb/tb_kbd_scan_arbiter.sv
// Directed bench for kbd_scan_arbiter with a behavioural key matrix and a
// frame scoreboard of expected snapshots.
module tb_kbd_scan_arbiter;

  typedef struct {
    logic [63:0] map;
    logic        changed;
    logic        any_key;
  } frame_t;

  logic        clk_sys;
  logic        reset;
  logic        scan_en;
  logic        cpu_req;
  logic [2:0]  cpu_row;
  logic [7:0]  cpu_col;
  logic        key_hit;
  logic [2:0]  row;
  logic [7:0]  col;
  logic        cpu_key_hit;
  logic [63:0] map;
  logic        map_valid;
  logic        frame_done;
  logic        changed;
  logic        any_key;

  logic [63:0] pressed;
  logic [5:0]  row_base;
  logic [63:0] model_map;
  logic        model_first;
  frame_t      sb[$];
  int          n_checks;
  int          n_fail;

  kbd_scan_arbiter #(.SETTLE(2), .FRAME_GAP(4)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .scan_en     (scan_en),
    .cpu_req     (cpu_req),
    .cpu_row     (cpu_row),
    .cpu_col     (cpu_col),
    .key_hit     (key_hit),
    .row         (row),
    .col         (col),
    .cpu_key_hit (cpu_key_hit),
    .map         (map),
    .map_valid   (map_valid),
    .frame_done  (frame_done),
    .changed     (changed),
    .any_key     (any_key)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Matrix: a hit when any pulled-low column of the selected row is pressed.
  assign row_base = {row, 3'b000};
  assign key_hit  = |(pressed[row_base +: 8] & ~col);

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [63:0] keys);
    frame_t f;
    f.map       = keys;
    f.changed   = model_first || (keys != model_map);
    f.any_key   = |keys;
    model_map   = keys;
    model_first = 1'b0;
    sb.push_back(f);
  endtask

  // Waits for frame_done (bounded), checks latency, then the published snapshot.
  task automatic frame_check(input string tag, input int exp_len, input logic exp_cpu_hit);
    int     n;
    frame_t f;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_done && n < 2000);
    check({tag, "_done"}, frame_done, 1);
    check({tag, "_len"}, n, exp_len);
    check({tag, "_sb"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      f = sb.pop_front();
      check({tag, "_changed"}, changed, f.changed);
      check({tag, "_cpu_hit"}, cpu_key_hit, exp_cpu_hit);
      tick();
      check({tag, "_pulse"}, frame_done, 0);
      check({tag, "_map"}, map, f.map);
      check({tag, "_valid"}, map_valid, 1);
      check({tag, "_any"}, any_key, f.any_key);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_row"}, row, 0);
    check({tag, "_col"}, col, 8'hFF);
    check({tag, "_cpu_hit"}, cpu_key_hit, 0);
    check({tag, "_map"}, map, 0);
    check({tag, "_valid"}, map_valid, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_changed"}, changed, 0);
    check({tag, "_any"}, any_key, 0);
  endtask

  initial begin
    int seen;
    n_checks    = 0;
    n_fail      = 0;
    model_map   = '0;
    model_first = 1'b1;
    pressed     = '0;
    reset       = 1'b1;
    scan_en     = 1'b0;
    cpu_req     = 1'b0;
    cpu_row     = 3'd0;
    cpu_col     = 8'hFF;

    ticks(3);
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    // Frame 1: empty matrix, first publish always reports change.
    push_frame(64'h0);
    scan_en = 1'b1;
    frame_check("f1", 193, 0);

    // Frames 2 and 3: 'a' held (row 6, column bit 5).
    pressed = 64'h1 << 53;
    push_frame(pressed);
    frame_check("f2", 197, 0);
    push_frame(pressed);
    frame_check("f3", 197, 0);

    // Frame 4: CPU steals the matrix for 10 cycles mid-settle at idx 20.
    pressed = '0;
    push_frame(pressed);
    ticks(66);
    cpu_req = 1'b1;
    cpu_row = 3'd3;
    cpu_col = 8'hFE;
    #1;
    check("cpu_row", row, 3);
    check("cpu_col", col, 8'hFE);
    ticks(10);
    cpu_req = 1'b0;
    cpu_row = 3'd0;
    cpu_col = 8'hFF;
    #1;
    check("resume_row", row, 2);
    check("resume_col", col, 8'hEF);
    frame_check("f4", 132, 0);

    // CPU reads space (row 4, bit 0), then an unpressed key, during the gap.
    pressed = 64'h1 << 32;
    push_frame(pressed);
    cpu_req = 1'b1;
    cpu_row = 3'd4;
    cpu_col = 8'hFE;
    tick();
    check("cpu_hit_c2", cpu_key_hit, 0);
    tick();
    check("cpu_hit_c3", cpu_key_hit, 1);
    cpu_col = 8'hFD;
    tick();
    tick();
    check("cpu_hit_release", cpu_key_hit, 0);
    cpu_req = 1'b0;
    cpu_row = 3'd0;
    cpu_col = 8'hFF;
    frame_check("f5", 193, 0);

    // Frame 6 aborted at idx 40: nothing published.
    pressed = 64'h1;
    ticks(125);
    scan_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (frame_done) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_map", map, 64'h1 << 32);
    check("abort_valid", map_valid, 1);
    check("abort_row", row, 0);
    check("abort_col", col, 8'hFF);

    // Re-enable: scan restarts at idx 0.
    push_frame(pressed);
    scan_en = 1'b1;
    tick();
    check("restart_row", row, 0);
    check("restart_col", col, 8'hFE);
    frame_check("f7", 192, 0);

    // Reset during the gap.
    tick();
    reset = 1'b1;
    #1;
    check_reset_values("midgap");
    check("sb_empty", sb.size(), 0);
    ticks(2);
    reset = 1'b0;

    $display("[TB] %0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/kbd_scan_arbiter.md
Name: kbd_scan_arbiter

Overview:
- Shares the Oric keyboard matrix (3-bit row select, 8-bit one-cold column mask, 1-bit key_hit return) between the CPU path (VIA port B / AY port A) and a background hardware scanner.
- The CPU always has priority.
- In idle cycles, the scanner walks all 64 matrix positions and publishes a 64-bit key map snapshot plus change/any-key flags for OSD, autotype-sync and wake logic.

Parameters:
- SETTLE, 2: cycles from driving a position to sampling key_hit. Must be ≥1; the matrix registers row decode one cycle.
- FRAME_GAP, 1000: idle cycles between frames. 0 means back-to-back.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous active-high reset
- scan_en  in  1  enables background scanning
- cpu_req  in  1  CPU owns the matrix this cycle
- cpu_row  in  3  CPU row select
- cpu_col  in  8  CPU column mask (one-cold)
- key_hit  in  1  matrix hit return
- row  out  3  row to matrix
- col  out  8  column mask to matrix
- cpu_key_hit  out  1  hit value presented to CPU
- map  out  64  published snapshot; bit row*8+j = key at row, column bit j
- map_valid  out  1  a full frame has been published since reset (sticky)
- frame_done  out  1  one-cycle pulse on publish
- changed  out  1  one-cycle pulse with frame_done when the new map differs from the previous one
- any_key  out  1  |map

Behaviour:
- Reset values: row=0, col=8'hFF, cpu_key_hit=0, map=0, map_valid=0, frame_done=0, changed=0, any_key=0. Shadow map=0, idx=0, FSM in IDLE.
- Ownership:
  - cpu_req=1: row/col = cpu_row/cpu_col, combinational, same cycle.
  - Otherwise, scanner in DRIVE/SETTLE: row=idx[5:3], col=~(8'b1<<idx[2:0]).
  - Otherwise: row=0, col=8'hFF.
- cpu_key_hit: registered. Loads key_hit on cycles where cpu_req is high in both the current and the previous cycle; holds otherwise. CPU therefore never sees scanner-position hits.
- FSM states: IDLE, SETTLE, SAMPLE, PUBLISH, GAP. Timer is a counter of ≥16 bits.
  - IDLE: if scan_en, clear idx, shadow, timer → SETTLE.
  - SETTLE: timer counts 1..SETTLE while cpu_req=0. At timer==SETTLE → SAMPLE.
  - SAMPLE (1 cycle): shadow[idx] <= ~key_hit... no: shadow[idx] <= key_hit. If idx==63 → PUBLISH; else idx++, timer=0 → SETTLE.
  - PUBLISH (1 cycle): map <= shadow; map_valid <= 1; frame_done=1.
    - changed=1 if shadow≠map, or if map_valid was 0 (first frame always reports change).
    - → GAP, timer=0.
  - GAP: counts FRAME_GAP cycles (FRAME_GAP=0: zero cycles) → IDLE.
- CPU preemption: cpu_req=1 in SETTLE or SAMPLE forces timer=0 and stays in SETTLE; no sample is taken. The position is re-settled from scratch after cpu_req drops. cpu_req in IDLE/PUBLISH/GAP has no effect on the FSM.
- scan_en=0 in any state except PUBLISH: next state IDLE; shadow discarded; map, map_valid retained. PUBLISH always completes.
- Frame length with no CPU activity: 64*(SETTLE+1) + 1 + FRAME_GAP + 1 (IDLE) cycles.
- any_key: registered from map, updated the cycle after PUBLISH.
- Reset mid-frame: immediate return to reset values; no partial publish.

Decomposition:
- Package oric_kbd_pkg:
  - scan state enum
  - MATRIX_ROWS=8, MATRIX_COLS=8, MAP_W=64
  - function col_onecold(idx[2:0])
- One natural sub-module: kbd_scan_timer, a settle/gap counter with clear, enable and terminal-count compare, shared by the SETTLE and GAP states.
- Arbiter mux and FSM stay in the top module.

Test Plan:
- Reset, then scan_en=1, no keys, SETTLE=2, FRAME_GAP=4 → frame_done at cycle 193 after leaving IDLE; map=0, map_valid=1, changed=1, any_key=0.
- Hold key 'a' (row 6, col bit 5) through the second frame → map[53]=1 only; changed=1, any_key=1. Third frame unchanged → changed=0.
- cpu_req=1 for 10 cycles mid-SETTLE at idx=20 with cpu_row=3, cpu_col=8'hFE → row=3, col=FE the same cycle. After release, idx 20 re-settles the full SETTLE cycles; frame_done delayed by exactly 10 + the settle progress lost.
- CPU holds row 4 / col 8'hFE (space) pressed for 3 cycles → cpu_key_hit=1 from the 3rd cycle; scanner positions hitting afterward do not change cpu_key_hit.
- Drop scan_en at idx=40 → FSM to IDLE, no frame_done, map unchanged. Re-enable → scan restarts at idx=0.
- Assert reset mid-GAP → all outputs at reset values the same cycle; map_valid=0.
